output_memory_node: RTL
=======================

// Module: output_memory_node
// PURPOSE
// - Write-side counterpart of the CGRA input memory nodes. Accepts a valid/ready word stream from the output data mover.
// - Buffers the words in a FIFO and stores them to memory as single-word OBI writes at base + k*stride.
// - Raises done_o once every write has been granted and acknowledged (rvalid).
// - One instance per CGRA output column, on the same OBI master bus as the input nodes.
// PARAMETERS
// - FIFO_DEPTH       4  data FIFO entries (power of 2, >=2)
// - MAX_OUTSTANDING  4  max granted writes awaiting rvalid (>=1)
// PORTS
// - clk_i           in   1        clock, all logic on rising edge
// - rst_i           in   1        synchronous active-high reset
// - clr_i           in   1        synchronous clear, same effect as rst_i (FIFO flushed)
// - exec_i          in   1        execution phase active
// - output_addr_i   in   32       base byte address
// - output_size_i   in   16       region size in bytes, 0 = no writes
// - output_stride_i in   16       byte step between words
// - masters_req_o   out  obi_req_t  req/we/be/addr/wdata to OBI
// - masters_resp_i  in   obi_resp_t gnt/rvalid from OBI
// - din_i           in   32       data word from IDM/CGRA
// - din_v_i         in   1        din_i valid
// - din_r_o         out  1        node ready for din_i
// - done_o          out  1        all writes complete
// BEHAVIOUR
// - Reset/clear: state S_IDLE; acc_off, wr_off, outstanding = 0; FIFO empty.
//   req = 0, din_r_o = 0, done_o = 0. Any stray rvalid after reset is ignored.
// - Fixed OBI fields: we = 1, be = 4'b1111, wdata = FIFO head, addr = output_addr_i + {16'h0, wr_off} (32-bit wrap).
// - Offset arithmetic is 17-bit: n_off = {1'b0, off} + stride, so the end compare never wraps.
// - Word count N = ceil(size/stride). stride==0 with size!=0 -> exactly one word at the base address.
// - FSM:
//   - S_IDLE: exec_i & size!=0 -> S_WRITE; exec_i & size==0 -> S_DONE; else stay.
//   - S_WRITE: -> S_DRAIN on the grant whose n_wr_off >= size (or stride==0).
//   - S_DRAIN: -> S_DONE when outstanding==0, or outstanding==1 with rvalid this cycle.
//   - S_DONE: stay until rst_i/clr_i. done_o = (state==S_DONE), registered-state decode.
// - Input side:
//   - din_r_o = (state==S_WRITE) & !full & !acc_last.
//   - Accept = din_v_i & din_r_o: push FIFO, acc_off <= n_acc_off.
//   - acc_last sets when n_acc_off >= size (or stride==0); no word beyond N is ever accepted.
//   - din_r_o does not depend on din_v_i.
// - Output side:
//   - req = (state==S_WRITE) & !empty & (outstanding < MAX_OUTSTANDING).
//   - Once req is asserted, addr/wdata stay stable until gnt.
//   - On req & gnt: pop FIFO, wr_off <= n_wr_off, outstanding +1.
// - rvalid: outstanding -1. Simultaneous grant and rvalid -> net 0. Never underflows; saturates at 0.
// - Simultaneous push and pop on a full FIFO: pop frees the slot next cycle; din_r_o stays low that cycle (no combinational full bypass).
// - Latency: first req at earliest 1 cycle after the accept (FIFO registered). Throughput 1 word/cycle with gnt held high.
// - exec_i deasserting mid-transfer does not abort; only rst_i/clr_i abort. Abort drops un-acked writes from tracking.
// TESTING
// - size=16, stride=4, base=0x1000, din 0xA0..0xA3, gnt/rvalid every cycle
//   -> writes to 0x1000/04/08/0C with wdata A0..A3; done_o 1 cycle after the last rvalid.
// - size=0, exec_i pulse -> S_DONE next cycle; din_r_o and req never assert.
// - size=10, stride=4 -> 3 writes at +0/+4/+8; a 4th din_v_i is never accepted (din_r_o=0).
// - gnt held low 20 cycles, din_v_i constant -> exactly FIFO_DEPTH words accepted, then din_r_o=0.
//   Release gnt -> all words written in order.
// - rvalid delayed 10 cycles, MAX_OUTSTANDING=4, 8 words -> req drops after 4 grants; done only after the 8th rvalid.
// - clr_i mid-transfer (2 of 4 words granted) -> next cycle req=0, din_r_o=0, done_o=0, FIFO empty.
//   A rerun with size=8 writes exactly 2 words.

Source files
------------

// File: rtl/output_memory_node_if.sv
// rtl/output_memory_node_if.sv - OBI write-master bus between an output memory node and memory
// Carries a single-word write request and its grant/response handshake.
interface output_memory_node_if;
  logic        req;
  logic        we;
  logic [3:0]  be;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        gnt;
  logic        rvalid;

  modport master (output req, we, be, addr, wdata, input gnt, rvalid);
  modport slave  (input req, we, be, addr, wdata, output gnt, rvalid);
endinterface

// File: rtl/output_memory_node.sv
// rtl/output_memory_node.sv - buffers a word stream and stores it as OBI writes at base + k*stride
// Raises done_o once every issued write has been granted and acknowledged.
module output_memory_node #(
  parameter int unsigned FIFO_DEPTH      = 4,
  parameter int unsigned MAX_OUTSTANDING = 4
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  input  logic                        clr_i,
  input  logic                        exec_i,
  input  logic [31:0]                 output_addr_i,
  input  logic [15:0]                 output_size_i,
  input  logic [15:0]                 output_stride_i,
  output_memory_node_if.master        masters_if,
  input  logic [31:0]                 din_i,
  input  logic                        din_v_i,
  output logic                        din_r_o,
  output logic                        done_o
);
  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned OW = $clog2(MAX_OUTSTANDING + 1);
  localparam logic [OW-1:0] MAX_OUT = OW'(MAX_OUTSTANDING);
  localparam logic [OW-1:0] ONE_OUT = OW'(1);

  typedef enum logic [1:0] {S_IDLE, S_WRITE, S_DRAIN, S_DONE} state_t;

  state_t        state_q, state_d;
  logic [31:0]   mem_q [FIFO_DEPTH];
  logic [AW:0]   wptr_q, rptr_q;
  logic [15:0]   acc_off_q, wr_off_q;
  logic          acc_last_q;
  logic [OW-1:0] outstanding_q, outstanding_d;

  logic [16:0]   n_acc_off, n_wr_off;
  logic          abort, stride_zero, acc_end, wr_end;
  logic          empty, full, accept, grant, ack;

  assign abort       = rst_i | clr_i;
  assign stride_zero = (output_stride_i == 16'h0);

  // 17-bit offsets so the end-of-region compare cannot wrap past size
  assign n_acc_off = {1'b0, acc_off_q} + {1'b0, output_stride_i};
  assign n_wr_off  = {1'b0, wr_off_q} + {1'b0, output_stride_i};
  assign acc_end   = stride_zero | (n_acc_off >= {1'b0, output_size_i});
  assign wr_end    = stride_zero | (n_wr_off >= {1'b0, output_size_i});

  assign empty = (wptr_q == rptr_q);
  assign full  = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);

  assign din_r_o = (state_q == S_WRITE) & ~full & ~acc_last_q;
  assign accept  = din_v_i & din_r_o;

  assign masters_if.req   = (state_q == S_WRITE) & ~empty & (outstanding_q < MAX_OUT);
  assign masters_if.we    = 1'b1;
  assign masters_if.be    = 4'b1111;
  assign masters_if.wdata = mem_q[rptr_q[AW-1:0]];
  assign masters_if.addr  = output_addr_i + {16'h0, wr_off_q};

  assign grant  = masters_if.req & masters_if.gnt;
  // a response with nothing in flight is a leftover from before an abort
  assign ack    = masters_if.rvalid & (outstanding_q != '0);
  assign done_o = (state_q == S_DONE);

  always_comb begin
    outstanding_d = outstanding_q;
    case ({grant, ack})
      2'b10:   outstanding_d = outstanding_q + ONE_OUT;
      2'b01:   outstanding_d = outstanding_q - ONE_OUT;
      default: outstanding_d = outstanding_q;
    endcase
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (exec_i) state_d = (output_size_i == 16'h0) ? S_DONE : S_WRITE;
      S_WRITE: if (grant && wr_end) state_d = S_DRAIN;
      S_DRAIN: if ((outstanding_q == '0) || ((outstanding_q == ONE_OUT) && masters_if.rvalid))
                 state_d = S_DONE;
      S_DONE:  state_d = S_DONE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (abort) begin
      state_q       <= S_IDLE;
      wptr_q        <= '0;
      rptr_q        <= '0;
      acc_off_q     <= '0;
      wr_off_q      <= '0;
      acc_last_q    <= 1'b0;
      outstanding_q <= '0;
    end else begin
      state_q       <= state_d;
      outstanding_q <= outstanding_d;
      if (accept) begin
        wptr_q    <= wptr_q + (AW+1)'(1);
        acc_off_q <= n_acc_off[15:0];
        if (acc_end) acc_last_q <= 1'b1;
      end
      if (grant) begin
        rptr_q   <= rptr_q + (AW+1)'(1);
        wr_off_q <= n_wr_off[15:0];
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (accept) mem_q[wptr_q[AW-1:0]] <= din_i;
  end
endmodule
